// File: rtl/ps2_mouse_tracker.sv
// PS/2 stream-mode packet assembler: 3-byte packets -> clamped absolute cursor and left-click pulse.
// Optional inter-byte timeout enabled by defining MOUSE_TIMEOUT_EN.
module ps2_mouse_tracker #(
  parameter int X_MAX          = 239,
  parameter int Y_MAX          = 319,
  parameter int X_INIT         = 120,
  parameter int Y_INIT         = 160,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] mouse_xpos,
  output logic [8:0] mouse_ypos,
  output logic       left_btn,
  output logic       pos_valid,
  output logic       left_click,
  output logic       packet_error
);

  typedef enum logic [1:0] {B0, B1, B2} state_t;

  localparam logic signed [10:0] XMAX_S = 11'(X_MAX);
  localparam logic signed [10:0] YMAX_S = 11'(Y_MAX);

  state_t      state_q;
  // Header kept as {y_ovf, x_ovf, y_sign, x_sign, left}
  logic [4:0]  hdr_q;
  logic [7:0]  dxb_q;
  logic [7:0]  xpos_q;
  logic [8:0]  ypos_q;
  logic        btn_q;
  logic        pos_valid_q;
  logic        click_q;
  logic        err_q;

  logic signed [8:0]  dx_d;
  logic signed [8:0]  dy_d;
  logic signed [10:0] nx_d;
  logic signed [10:0] ny_d;
  logic [7:0]         xpos_d;
  logic [8:0]         ypos_d;

  function automatic logic [7:0] clamp_x(input logic signed [10:0] v);
    if (v < 0)           return 8'd0;
    else if (v > XMAX_S) return XMAX_S[7:0];
    else                 return v[7:0];
  endfunction

  function automatic logic [8:0] clamp_y(input logic signed [10:0] v);
    if (v < 0)           return 9'd0;
    else if (v > YMAX_S) return YMAX_S[8:0];
    else                 return v[8:0];
  endfunction

  // The y byte is consumed straight from rx_data so the packet lands on the same edge.
  always_comb begin
    dx_d   = hdr_q[3] ? 9'sd0 : $signed({hdr_q[1], dxb_q});
    dy_d   = hdr_q[4] ? 9'sd0 : $signed({hdr_q[2], rx_data});
    nx_d   = $signed({3'b000, xpos_q}) + $signed({{2{dx_d[8]}}, dx_d});
    ny_d   = $signed({2'b00, ypos_q}) - $signed({{2{dy_d[8]}}, dy_d});
    xpos_d = clamp_x(nx_d);
    ypos_d = clamp_y(ny_d);
  end

`ifdef MOUSE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             tmo;
  // An arriving byte always beats an expiring counter.
  assign tmo = (state_q != B0) && !rx_valid && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= B0;
      hdr_q       <= '0;
      dxb_q       <= '0;
      xpos_q      <= 8'(X_INIT);
      ypos_q      <= 9'(Y_INIT);
      btn_q       <= 1'b0;
      pos_valid_q <= 1'b0;
      click_q     <= 1'b0;
      err_q       <= 1'b0;
`ifdef MOUSE_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      pos_valid_q <= 1'b0;
      click_q     <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        B0: if (rx_valid) begin
          if (rx_data[3]) begin
            hdr_q   <= {rx_data[7:4], rx_data[0]};
            state_q <= B1;
          end else begin
            err_q   <= 1'b1;
          end
        end
        B1: if (rx_valid) begin
          dxb_q   <= rx_data;
          state_q <= B2;
        end
        B2: if (rx_valid) begin
          xpos_q      <= xpos_d;
          ypos_q      <= ypos_d;
          btn_q       <= hdr_q[0];
          click_q     <= hdr_q[0] & ~btn_q;
          pos_valid_q <= 1'b1;
          state_q     <= B0;
        end
        default: state_q <= B0;
      endcase
`ifdef MOUSE_TIMEOUT_EN
      if (tmo) begin
        state_q <= B0;
        err_q   <= 1'b1;
      end
      if (state_q == B0 || rx_valid || tmo) cnt_q <= '0;
      else                                  cnt_q <= cnt_q + 1'b1;
`endif
    end
  end

  assign mouse_xpos   = xpos_q;
  assign mouse_ypos   = ypos_q;
  assign left_btn     = btn_q;
  assign pos_valid    = pos_valid_q;
  assign left_click   = click_q;
  assign packet_error = err_q;

endmodule
